// File: rtl/data_mem_ctrl_if.sv
// Core-to-data-memory bus: request level, address/data, and response signals.
interface data_mem_ctrl_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic [31:0] dReadData;
  logic        mem_ready;
  logic        mem_error;
  logic [15:0] access_count;

  // Core side: issues requests, consumes responses.
  modport master (
    output MemRead,
    output MemWrite,
    output dAddress,
    output dWriteData,
    input  dReadData,
    input  mem_ready,
    input  mem_error,
    input  access_count
  );

  // Memory side: accepts requests, produces registered responses.
  modport slave (
    input  MemRead,
    input  MemWrite,
    input  dAddress,
    input  dWriteData,
    output dReadData,
    output mem_ready,
    output mem_error,
    output access_count
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Wait-stated word RAM behind the multicycle core's data port.
// A request level sampled in IDLE is either rejected straight away (fault)
// or served after WAIT_CYCLES+1 edges; every response is a single-cycle
// mem_ready pulse, and HOLD swallows a request level that stays high.
module data_mem_ctrl #(
  parameter int unsigned ADDR_BITS   = 7,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_ctrl_if.slave bus
);

  localparam int unsigned DEPTH     = 1 << ADDR_BITS;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Word storage; never cleared by reset.
  logic [31:0] ram [0:DEPTH-1];

  logic [1:0]           state_reg;
  logic [1:0]           state_next;
  logic [3:0]           wait_reg;
  logic [3:0]           wait_next;
  logic [ADDR_BITS-1:0] index_reg;
  logic [31:0]          wdata_reg;
  logic                 write_reg;
  logic [31:0]          rdata_reg;
  logic                 ready_reg;
  logic                 error_reg;
  logic [15:0]          count_reg;

  // Request decode. Offset is a plain 32-bit unsigned difference: an
  // address below the base wraps to a huge offset, so one "upper bits
  // clear" test covers both the below-window and above-window cases.
  logic                 request;
  logic                 both_ops;
  logic                 misaligned;
  logic                 out_of_window;
  logic                 fault;
  logic [31:0]          offset;
  logic [ADDR_BITS-1:0] req_index;
  logic                 accept;
  logic                 commit;

  assign request       = bus.MemRead | bus.MemWrite;
  assign both_ops      = bus.MemRead & bus.MemWrite;
  assign offset        = bus.dAddress - BASE_ADDR;
  // Base is word aligned, so the offset's low bits equal the address's.
  assign misaligned    = (offset[1:0] != 2'b00);
  assign out_of_window = (offset[31:ADDR_BITS+2] != '0);
  assign fault         = both_ops | misaligned | out_of_window;
  assign req_index     = offset[ADDR_BITS+1:2];

  // A request is accepted only when sampled in IDLE.
  assign accept = (state_reg == ST_IDLE) && request;
  // Final WAIT edge: the RAM access itself happens here.
  assign commit = (state_reg == ST_WAIT) && (wait_reg == 4'd0);

  // Next-state and wait-counter logic.
  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    case (state_reg)
      ST_IDLE: begin
        if (request) begin
          state_next = fault ? ST_RESP : ST_WAIT;
          wait_next  = fault ? 4'd0 : WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (wait_reg == 4'd0) begin
          state_next = ST_RESP;
        end else begin
          wait_next = wait_reg - 4'd1;
        end
      end
      ST_RESP: begin
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (!request) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        wait_next  = 4'd0;
      end
    endcase
  end

  // FSM state, wait counter and registered response flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      wait_reg  <= 4'd0;
      ready_reg <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      ready_reg <= (state_next == ST_RESP);
      error_reg <= accept && fault;
    end
  end

  // Capture the request at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      index_reg <= '0;
      wdata_reg <= 32'd0;
      write_reg <= 1'b0;
    end else if (accept) begin
      index_reg <= req_index;
      wdata_reg <= bus.dWriteData;
      write_reg <= bus.MemWrite;
    end
  end

  // RAM write port; a reset on the commit edge cancels the write.
  always_ff @(posedge clk) begin
    if (rst && commit && write_reg) begin
      ram[index_reg] <= wdata_reg;
    end
  end

  // Registered RAM read into the load-data output, held between reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_reg <= 32'd0;
    end else if (commit && !write_reg) begin
      rdata_reg <= ram[index_reg];
    end
  end

  // Saturating count of completed (non-faulted) accesses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= 16'd0;
    end else if (commit && (count_reg != 16'hFFFF)) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign bus.dReadData    = rdata_reg;
  assign bus.mem_ready    = ready_reg;
  assign bus.mem_error    = error_reg;
  assign bus.access_count = count_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: one instance with WAIT_CYCLES=2,
// one with WAIT_CYCLES=0. Expected responses are queued when a request is
// driven and matched against each mem_ready pulse.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl_if bus_a ();
  data_mem_ctrl_if bus_b ();

  data_mem_ctrl #(
    .ADDR_BITS  (7),
    .BASE_ADDR  (32'h0000_0400),
    .WAIT_CYCLES(2)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(bus_a)
  );

  data_mem_ctrl #(
    .ADDR_BITS  (7),
    .BASE_ADDR  (32'h0000_0400),
    .WAIT_CYCLES(0)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(bus_b)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [15:0] cnt;
    int          due;
  } exp_t;

  typedef struct {
    logic [1:0]  op;     // {MemWrite, MemRead}
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t mon_a;
  exp_t mon_b;
  vec_t vecs[16];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] cnt_a    = 16'd0;
  logic [15:0] cnt_b    = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Response monitor for the WAIT_CYCLES=2 instance.
  always @(negedge clk) begin
    if (bus_a.mem_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_ready: got mem_ready=1 at cycle %0d expected no response", cyc);
      end else begin
        mon_a = q_a.pop_front();
        check("a_latency", 32'(cyc), 32'(mon_a.due));
        check("a_error", {31'd0, bus_a.mem_error}, {31'd0, mon_a.err});
        check("a_rdata", bus_a.dReadData, mon_a.rdata);
        check("a_count", {16'd0, bus_a.access_count}, {16'd0, mon_a.cnt});
        $display("a resp cyc=%0d err=%0b rdata=%h cnt=%0d", cyc, bus_a.mem_error,
                 bus_a.dReadData, bus_a.access_count);
      end
    end else if (bus_a.mem_error === 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL a_error_without_ready: got mem_error=1 expected 0 at cycle %0d", cyc);
    end
  end

  // Response monitor for the WAIT_CYCLES=0 instance.
  always @(negedge clk) begin
    if (bus_b.mem_ready === 1'b1) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_ready: got mem_ready=1 at cycle %0d expected no response", cyc);
      end else begin
        mon_b = q_b.pop_front();
        check("b_latency", 32'(cyc), 32'(mon_b.due));
        check("b_error", {31'd0, bus_b.mem_error}, {31'd0, mon_b.err});
        check("b_rdata", bus_b.dReadData, mon_b.rdata);
        check("b_count", {16'd0, bus_b.access_count}, {16'd0, mon_b.cnt});
        $display("b resp cyc=%0d err=%0b rdata=%h cnt=%0d", cyc, bus_b.mem_error,
                 bus_b.dReadData, bus_b.access_count);
      end
    end else if (bus_b.mem_error === 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL b_error_without_ready: got mem_error=1 expected 0 at cycle %0d", cyc);
    end
  end

  task automatic drive(input bit sel, input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (sel) begin
      bus_b.MemRead    = op[0];
      bus_b.MemWrite   = op[1];
      bus_b.dAddress   = addr;
      bus_b.dWriteData = wdata;
    end else begin
      bus_a.MemRead    = op[0];
      bus_a.MemWrite   = op[1];
      bus_a.dAddress   = addr;
      bus_a.dWriteData = wdata;
    end
  endtask

  // Queue the expected response for a request driven at this negedge.
  task automatic push_exp(input bit sel, input logic err, input logic [31:0] rdata);
    exp_t e;
    int   lat;
    lat = err ? 0 : (sel ? 1 : 3);
    if (!err) begin
      if (sel) cnt_b = cnt_b + 16'd1;
      else     cnt_a = cnt_a + 16'd1;
    end
    e.err   = err;
    e.rdata = rdata;
    e.cnt   = sel ? cnt_b : cnt_a;
    e.due   = cyc + 1 + lat;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  // One complete access: request held for 'hold' cycles, then the bus is
  // scrambled (must be ignored) and the bench waits for the response.
  task automatic access(input bit sel, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input logic err,
                        input logic [31:0] rdata);
    int waited;
    push_exp(sel, err, rdata);
    drive(sel, op, addr, wdata);
    repeat (hold) @(negedge clk);
    drive(sel, 2'b00, $urandom, $urandom);
    waited = 0;
    while (((sel ? q_b.size() : q_a.size()) != 0) && (waited < 40)) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no mem_ready expected a response for addr %h",
               sel ? "b" : "a", addr);
      if (sel) q_b.delete();
      else     q_a.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{2'b10, 32'h0000_0400, 32'hDEAD_BEEF, 6, 1'b0, 32'h0000_0000};
    vecs[1]  = '{2'b01, 32'h0000_0400, 32'h0000_0000, 1, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{2'b10, 32'h0000_05FC, 32'hCAFE_F00D, 2, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{2'b01, 32'h0000_05FC, 32'h0000_0000, 1, 1'b0, 32'hCAFE_F00D};
    vecs[4]  = '{2'b10, 32'h0000_0600, 32'h1111_1111, 1, 1'b1, 32'hCAFE_F00D};
    vecs[5]  = '{2'b01, 32'h0000_03FC, 32'h0000_0000, 1, 1'b1, 32'hCAFE_F00D};
    vecs[6]  = '{2'b10, 32'h0000_0404, 32'hA5A5_A5A5, 1, 1'b0, 32'hCAFE_F00D};
    vecs[7]  = '{2'b01, 32'h0000_0402, 32'h0000_0000, 1, 1'b1, 32'hCAFE_F00D};
    vecs[8]  = '{2'b11, 32'h0000_0404, 32'h0BAD_BAD0, 1, 1'b1, 32'hCAFE_F00D};
    vecs[9]  = '{2'b01, 32'h0000_0404, 32'h0000_0000, 3, 1'b0, 32'hA5A5_A5A5};
    vecs[10] = '{2'b10, 32'h0000_0408, 32'h0000_1111, 1, 1'b0, 32'hA5A5_A5A5};
    vecs[11] = '{2'b01, 32'h0000_0400, 32'h0000_0000, 1, 1'b0, 32'hDEAD_BEEF};
    vecs[12] = '{2'b01, 32'hFFFF_FFFC, 32'h0000_0000, 1, 1'b1, 32'hDEAD_BEEF};
    vecs[13] = '{2'b10, 32'h0000_0000, 32'h2222_2222, 1, 1'b1, 32'hDEAD_BEEF};
    vecs[14] = '{2'b01, 32'h0000_05FC, 32'h0000_0000, 4, 1'b0, 32'hCAFE_F00D};
    vecs[15] = '{2'b01, 32'h0000_0408, 32'h0000_0000, 1, 1'b0, 32'h0000_1111};

    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    drive(1'b1, 2'b00, 32'd0, 32'd0);
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    check("a_reset_rdata", bus_a.dReadData, 32'd0);
    check("a_reset_ready", {31'd0, bus_a.mem_ready}, 32'd0);
    check("a_reset_error", {31'd0, bus_a.mem_error}, 32'd0);
    check("a_reset_count", {16'd0, bus_a.access_count}, 32'd0);
    check("b_reset_rdata", bus_b.dReadData, 32'd0);
    check("b_reset_ready", {31'd0, bus_b.mem_ready}, 32'd0);
    check("b_reset_count", {16'd0, bus_b.access_count}, 32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);

    // Table of accesses against the WAIT_CYCLES=2 instance.
    for (int i = 0; i < 16; i++) begin
      access(1'b0, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
             vecs[i].err, vecs[i].rdata);
    end

    // Reset while a write is in WAIT: no response, write dropped.
    drive(1'b0, 2'b10, 32'h0000_0408, 32'h1234_5678);
    @(negedge clk);
    rst_a = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    check("a_midrst_rdata", bus_a.dReadData, 32'd0);
    check("a_midrst_ready", {31'd0, bus_a.mem_ready}, 32'd0);
    check("a_midrst_error", {31'd0, bus_a.mem_error}, 32'd0);
    check("a_midrst_count", {16'd0, bus_a.access_count}, 32'd0);
    cnt_a = 16'd0;
    rst_a = 1'b1;
    repeat (6) @(negedge clk);
    access(1'b0, 2'b01, 32'h0000_0408, 32'd0, 1, 1'b0, 32'h0000_1111);

    // WAIT_CYCLES=0: write, then a read level held for 10 cycles.
    access(1'b1, 2'b10, 32'h0000_0410, 32'h55AA_55AA, 1, 1'b0, 32'h0000_0000);
    push_exp(1'b1, 1'b0, 32'h55AA_55AA);
    drive(1'b1, 2'b01, 32'h0000_0410, 32'd0);
    repeat (10) @(negedge clk);
    check("b_held_single_resp", 32'(q_b.size()), 32'd0);
    drive(1'b1, 2'b00, 32'h0000_0410, 32'd0);
    @(negedge clk);
    // Reassert after a single low cycle: a second response follows.
    access(1'b1, 2'b01, 32'h0000_0410, 32'd0, 3, 1'b0, 32'h55AA_55AA);
    // Fault on the zero-wait instance keeps dReadData.
    access(1'b1, 2'b01, 32'h0000_0600, 32'd0, 1, 1'b1, 32'h55AA_55AA);

    repeat (4) @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
